// File: rtl/pipe_pkg.sv
// Shared pipeline-register types and per-stage widths.
// Imported by pipe_slot and pipe_stage_elastic; PIPE_SKID_EN selects the two-slot build.
package pipe_pkg;

  localparam int CTRL_W_DEF = 20;
  localparam int DATA_W_DEF = 48;

  typedef logic [CTRL_W_DEF-1:0] ctrl_bubble_t;
  localparam ctrl_bubble_t CTRL_BUBBLE_DEF = '0;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 48;
  localparam int IDEX_CTRL_W  = 20;
  localparam int EXMEM_DATA_W = 72;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 40;
  localparam int MEMWB_CTRL_W = 4;

  typedef logic [1:0] pipe_occ_t;

  function automatic pipe_occ_t occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + payload + control register.
// clear kills to bubble (payload held), load captures, drop empties.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 20,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= CTRL_BUBBLE;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end else if (drop) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register with valid/ready, stall and flush.
// Define PIPE_SKID_EN for the two-slot build with a registered in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 20,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output pipe_occ_t         occupancy
);

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready;
  assign emit   = main_v & out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              skid_drop;
  logic              skid_v_next;
  logic              rdy_q;

  assign in_ready = rdy_q & !flush;

  // Skid always drains into main first so arrival order is kept.
  assign main_load = !flush & ((skid_v & emit) |
                     (accept & !skid_v & (!main_v | emit)));
  assign main_drop = !flush & emit & !skid_v & !accept;
  assign main_d_data = skid_v ? skid_data : in_data;
  assign main_d_ctrl = skid_v ? skid_ctrl : in_ctrl;

  assign skid_load = !flush & accept &
                     ((main_v & !emit) | (skid_v & emit));
  assign skid_drop = !flush & skid_v & emit & !accept;

  always_comb begin
    skid_v_next = skid_v;
    unique case (1'b1)
      flush:     skid_v_next = 1'b0;
      skid_load: skid_v_next = 1'b1;
      skid_drop: skid_v_next = 1'b0;
      default:   skid_v_next = skid_v;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_q <= 1'b1;
    else      rdy_q <= !skid_v_next;
  end

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (skid_load),
    .drop   (skid_drop),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .q_valid(skid_v),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );

  assign occupancy = occ_count(main_v, skid_v);
`else
  assign in_ready    = (!main_v | out_ready) & !flush;
  assign main_load   = accept;
  assign main_drop   = !flush & emit & !accept;
  assign main_d_data = in_data;
  assign main_d_ctrl = in_ctrl;
  assign occupancy   = occ_count(main_v, 1'b0);
`endif

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (main_load),
    .drop   (main_drop),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_valid(main_v),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : CTRL_BUBBLE;

endmodule
